// File: rtl/clk_ratio_meter_if.sv
// Measurement-side bundle of clk_ratio_meter: the clock under test, enable, and the result outputs.
interface clk_ratio_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             clk_in;
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             ratio_ok;
    logic             locked;
    logic             timeout_err;

    modport master (
        output clk_in, en,
        input  period, high_time, meas_valid, ratio_ok, locked, timeout_err
    );

    modport slave (
        input  clk_in, en,
        output period, high_time, meas_valid, ratio_ok, locked, timeout_err
    );
endinterface

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow divided clock in clk cycles, checks the ratio,
// declares lock after a run of equal periods and flags loss of the clock by timeout.
module clk_ratio_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned EXP_N    = 4,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input logic              clk,
    input logic              rst,
    clk_ratio_meter_if.slave bus
);

    localparam int unsigned DIFF_W  = CNT_W + 1;
    localparam int unsigned MATCH_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] LOCK_C    = MATCH_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic s1, s2, s3;
    logic rise_c, fall_c;

    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               first_q, first_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic               valid_q, valid_d;
    logic               ok_q, ok_d;
    logic               locked_q, locked_d;
    logic               tout_q, tout_d;

    logic [CNT_W-1:0]   per_inc_c, hi_inc_c;
    logic [MATCH_W-1:0] match_inc_c;
    logic signed [DIFF_W-1:0] diff_c, mag_c;
    logic               in_tol_c;

    // Two-flop synchronizer plus history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;
    assign fall_c = ~s2 & s3;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        per_inc_c   = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
        hi_inc_c    = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
        match_inc_c = (match_q >= LOCK_C) ? match_q : match_q + MATCH_W'(1);
        diff_c      = $signed({1'b0, per_cnt_q}) - $signed(DIFF_W'(EXP_N));
        mag_c       = diff_c[DIFF_W-1] ? -diff_c : diff_c;
        in_tol_c    = (mag_c <= $signed(DIFF_W'(TOL)));
    end

    // Next-state and next-register logic; en=0 overrides every state
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        match_d   = match_q;
        first_d   = first_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        ok_d      = ok_q;
        locked_d  = locked_q;
        tout_d    = tout_q;

        if (!bus.en) begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            match_d   = '0;
            first_d   = 1'b0;
            locked_d  = 1'b0;
            tout_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    match_d   = '0;
                    state_d   = ARM;
                end
                ARM: begin
                    if (rise_c) begin
                        per_cnt_d = CNT_W'(1);
                        hi_cnt_d  = CNT_W'(1);
                        first_d   = 1'b1;
                        state_d   = MEASURE;
                    end else if (per_cnt_q == TIMEOUT_C) begin
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                        match_d   = '0;
                        locked_d  = 1'b0;
                        tout_d    = 1'b1;
                    end else begin
                        per_cnt_d = per_inc_c;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise_c) begin
                        per_cnt_d = CNT_W'(1);
                        hi_cnt_d  = CNT_W'(1);
                        period_d  = per_cnt_q;
                        valid_d   = 1'b1;
                        ok_d      = in_tol_c;
                        first_d   = 1'b0;
                        if (first_q) begin
                            match_d = '0;
                        end else if (per_cnt_q == period_q) begin
                            match_d = match_inc_c;
                            if (match_inc_c >= LOCK_C) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            match_d  = '0;
                            locked_d = 1'b0;
                            state_d  = MEASURE;
                        end
                    end else if (per_cnt_q == TIMEOUT_C) begin
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                        match_d   = '0;
                        first_d   = 1'b0;
                        locked_d  = 1'b0;
                        tout_d    = 1'b1;
                        state_d   = ARM;
                    end else begin
                        per_cnt_d = per_inc_c;
                        if (s2)     hi_cnt_d = hi_inc_c;
                        if (fall_c) high_d   = hi_cnt_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            match_q   <= '0;
            first_q   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            ok_q      <= 1'b0;
            locked_q  <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            match_q   <= match_d;
            first_q   <= first_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            ok_q      <= ok_d;
            locked_q  <= locked_d;
            tout_q    <= tout_d;
        end
    end

    assign bus.period      = period_q;
    assign bus.high_time   = high_q;
    assign bus.meas_valid  = valid_q;
    assign bus.ratio_ok    = ok_q;
    assign bus.locked      = locked_q;
    assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: a default instance and a TOL=1 instance share one stimulus.
module tb_clk_ratio_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_in_r = 1'b0;
    logic en_r = 1'b0;

    always #5 clk = ~clk;

    clk_ratio_meter_if #(.CNT_W(16)) bus ();
    clk_ratio_meter_if #(.CNT_W(16)) bus_t ();

    assign bus.clk_in   = clk_in_r;
    assign bus.en       = en_r;
    assign bus_t.clk_in = clk_in_r;
    assign bus_t.en     = en_r;

    clk_ratio_meter #(.CNT_W(16), .EXP_N(4), .TOL(0), .LOCK_CNT(4), .TIMEOUT(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    clk_ratio_meter #(.CNT_W(16), .EXP_N(4), .TOL(1), .LOCK_CNT(4), .TIMEOUT(1024)) dut_tol (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int nvalid, first_mv, last_mv, lock_tick, unlock_tick, tout_tick;
    int rt [16];
    int nr;
    int last_rise;
    logic locked_prev = 1'b0;
    logic tout_prev   = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_marks();
        nvalid      = 0;
        first_mv    = -1;
        last_mv     = -1;
        lock_tick   = -1;
        unlock_tick = -1;
        tout_tick   = -1;
    endtask

    // One clk cycle: sample outputs on the falling edge, then drive clk_in
    task automatic tick(input logic v);
        @(negedge clk);
        cyc++;
        if (bus.meas_valid) begin
            nvalid++;
            if (first_mv < 0) first_mv = cyc;
            last_mv = cyc;
        end
        if (bus.locked && !locked_prev) lock_tick = cyc;
        if (!bus.locked && locked_prev) unlock_tick = cyc;
        if (bus.timeout_err && !tout_prev) tout_tick = cyc;
        locked_prev = bus.locked;
        tout_prev   = bus.timeout_err;
        if (v && !clk_in_r && nr < 16) begin
            rt[nr] = cyc;
            nr++;
        end
        clk_in_r = v;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        nr = 0;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) tick(1'b1);
            for (int i = 0; i < lo; i++) tick(1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, int'(bus.period), 0);
        check({tag, "_high"},   int'(bus.high_time), 0);
        check({tag, "_valid"},  int'(bus.meas_valid), 0);
        check({tag, "_ok"},     int'(bus.ratio_ok), 0);
        check({tag, "_locked"}, int'(bus.locked), 0);
        check({tag, "_tout"},   int'(bus.timeout_err), 0);
    endtask

    initial begin
        clear_marks();
        nr = 0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        rst = 1'b0;
        check_zero("reset");

        // clk/4 from enable: baseline at rise 2, lock at rise 6
        en_r = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        clear_marks();
        wave(2, 2, 8);
        check("a_first_mv",  first_mv, rt[1] + 3);
        check("a_last_mv",   last_mv, rt[7] + 3);
        check("a_nvalid",    nvalid, 7);
        check("a_lock_tick", lock_tick, rt[5] + 3);
        check("a_period",    int'(bus.period), 4);
        check("a_high",      int'(bus.high_time), 2);
        check("a_ok",        int'(bus.ratio_ok), 1);
        check("a_ok_tol",    int'(bus_t.ratio_ok), 1);
        check("a_tout",      int'(bus.timeout_err), 0);

        // Switch to clk/6: unlock on first 6, relock after 4 more matches
        clear_marks();
        wave(3, 3, 6);
        check("b_unlock",    unlock_tick, rt[1] + 3);
        check("b_relock",    lock_tick, rt[5] + 3);
        check("b_period",    int'(bus.period), 6);
        check("b_high",      int'(bus.high_time), 3);
        check("b_ok",        int'(bus.ratio_ok), 0);
        check("b_ok_tol",    int'(bus_t.ratio_ok), 0);
        last_rise = rt[5];

        // Loss of clock: timeout 1024 cycles after the last rise
        clear_marks();
        for (int i = 0; i < 1100; i++) tick(1'b0);
        check("c_tout_tick",   tout_tick, last_rise + 1027);
        check("c_unlock_tick", unlock_tick, last_rise + 1027);
        check("c_tout",        int'(bus.timeout_err), 1);
        check("c_locked",      int'(bus.locked), 0);

        clear_marks();
        wave(2, 2, 8);
        check("c_first_mv",  first_mv, rt[1] + 3);
        check("c_lock_tick", lock_tick, rt[5] + 3);
        check("c_period",    int'(bus.period), 4);
        check("c_tout_held", int'(bus.timeout_err), 1);

        // en low for 3 cycles while locked: clears flags, holds results
        clear_marks();
        en_r = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("d_locked",    int'(bus.locked), 0);
        check("d_tout",      int'(bus.timeout_err), 0);
        check("d_period",    int'(bus.period), 4);
        check("d_high",      int'(bus.high_time), 2);
        check("d_ok",        int'(bus.ratio_ok), 1);
        check("d_nvalid",    nvalid, 0);
        en_r = 1'b1;
        clear_marks();
        wave(2, 2, 3);
        check("d_first_mv",  first_mv, rt[1] + 3);
        check("d_nvalid2",   nvalid, 2);

        // clk/5 (3/2): inside TOL=1 only, then clk/6 leaves both
        wave(3, 2, 6);
        check("e_period",     int'(bus.period), 5);
        check("e_high",       int'(bus.high_time), 3);
        check("e_ok",         int'(bus.ratio_ok), 0);
        check("e_ok_tol",     int'(bus_t.ratio_ok), 1);
        check("e_period_tol", int'(bus_t.period), 5);
        check("e_locked",     int'(bus.locked), 1);
        wave(3, 3, 6);
        check("e6_ok_tol",    int'(bus_t.ratio_ok), 0);
        check("e6_period",    int'(bus.period), 6);
        check("e6_locked",    int'(bus.locked), 1);

        // One-cycle reset in the low phase while locked
        for (int i = 0; i < 3; i++) tick(1'b1);
        tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        check_zero("f_rst");
        clear_marks();
        tick(1'b0);
        tick(1'b0);
        wave(3, 3, 3);
        check("f_first_mv", first_mv, rt[1] + 3);
        check("f_nvalid",   nvalid, 2);
        check("f_period",   int'(bus.period), 6);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
